// File: rtl/app_stream_pkg.sv
// Shared types for the application-injection flit stream: field kinds and layout constants.
package app_stream_pkg;

  typedef enum logic [3:0] {
    K_DSIZE, K_TCNT, K_MAP, K_TAG, K_GRAPH,
    K_TXT, K_DATA, K_BSS, K_ENTRY, K_BIN
  } kind_t;

  localparam int unsigned TASK_TAG = 1;

  // Kinds that carry a meaningful task index on the output stream.
  function automatic logic is_task_kind(kind_t k);
    return k inside {K_MAP, K_TAG, K_TXT, K_DATA, K_BSS, K_ENTRY, K_BIN};
  endfunction

endpackage

// File: rtl/app_stream_rx_if.sv
// Input tx/credit flit handshake plus the tagged ready/valid output stream.
interface app_stream_rx_if
  import app_stream_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int MAX_TASKS = 32
);
  localparam int TW = $clog2(MAX_TASKS);

  logic                 tx_i;
  logic                 credit_o;
  logic [FLIT_SIZE-1:0] data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [FLIT_SIZE-1:0] out_data_o;
  kind_t                out_kind_o;
  logic [TW-1:0]        out_task_o;
  logic                 out_last_o;

  modport slave (
    input  tx_i, data_i, out_ready_i,
    output credit_o, out_valid_o, out_data_o, out_kind_o, out_task_o, out_last_o
  );

  modport master (
    output tx_i, data_i, out_ready_i,
    input  credit_o, out_valid_o, out_data_o, out_kind_o, out_task_o, out_last_o
  );

endinterface

// File: rtl/app_stream_rx_out_reg_slice.sv
// One-entry output register with valid/ready; credit frees up when the held entry retires.
module out_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         credit_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  // rst_ni is active-high here; no credit is granted while it is asserted.
  assign credit_o = !rst_ni && (!valid_q || out_ready_i);
  assign load     = in_valid_i && credit_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/app_stream_rx.sv
// Receiver for the application flit stream: parses the fixed layout and re-emits tagged flits.
module app_stream_rx
  import app_stream_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int MAX_TASKS = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  app_stream_rx_if.slave  bus,
  output logic            app_done_o,
  output logic            err_o,
  output logic [15:0]     app_cnt_o
);
  localparam int TW = $clog2(MAX_TASKS);
  localparam int PW = FLIT_SIZE + 4 + TW + 1;

  kind_t                state_q, state_d;
  logic [FLIT_SIZE-1:0] dsize_q, dsize_d, tcnt_q, tcnt_d, t_q, t_d, g_q, g_d;
  logic [FLIT_SIZE-1:0] words_q, words_d, b_q, b_d;
  logic [FLIT_SIZE:0]   bsum_q, bsum_d;
  logic                 err_q, err_d, done_q, done_d;
  logic [15:0]          app_cnt_q, app_cnt_d;

  logic                 acc, credit, app_end, task_end;
  logic [FLIT_SIZE-1:0] t_inc, g_inc, b_inc, words_new;
  logic [TW-1:0]        task_idx;
  logic [PW-1:0]        pl_in, pl_out;

  assign acc       = bus.tx_i && credit;
  assign t_inc     = t_q + 1'b1;
  assign g_inc     = g_q + 1'b1;
  assign b_inc     = b_q + 1'b1;
  assign words_new = FLIT_SIZE'(bsum_q >> 2);

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q   <= K_DSIZE;
      dsize_q   <= '0;
      tcnt_q    <= '0;
      t_q       <= '0;
      g_q       <= '0;
      bsum_q    <= '0;
      words_q   <= '0;
      b_q       <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      app_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dsize_q   <= dsize_d;
      tcnt_q    <= tcnt_d;
      t_q       <= t_d;
      g_q       <= g_d;
      bsum_q    <= bsum_d;
      words_q   <= words_d;
      b_q       <= b_d;
      err_q     <= err_d;
      done_q    <= done_d;
      app_cnt_q <= app_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dsize_d  = dsize_q;
    tcnt_d   = tcnt_q;
    t_d      = t_q;
    g_d      = g_q;
    bsum_d   = bsum_q;
    words_d  = words_q;
    b_d      = b_q;
    err_d    = err_q;
    app_end  = 1'b0;
    task_end = 1'b0;
    if (acc) begin
      unique case (state_q)
        K_DSIZE: begin
          dsize_d = bus.data_i;
          state_d = K_TCNT;
        end
        K_TCNT: begin
          tcnt_d = bus.data_i;
          t_d    = '0;
          if (bus.data_i > FLIT_SIZE'(MAX_TASKS)) err_d = 1'b1;
          if (bus.data_i != '0)      state_d = K_MAP;
          else if (dsize_q == '0)    app_end = 1'b1;
          else begin
            state_d = K_GRAPH;
            g_d     = '0;
          end
        end
        K_MAP: state_d = K_TAG;
        K_TAG: begin
          if (bus.data_i != FLIT_SIZE'(TASK_TAG)) err_d = 1'b1;
          t_d = t_inc;
          if (t_inc != tcnt_q) state_d = K_MAP;
          else if (dsize_q == '0) begin
            state_d = K_TXT;
            t_d     = '0;
          end else begin
            state_d = K_GRAPH;
            g_d     = '0;
          end
        end
        K_GRAPH: begin
          g_d = g_inc;
          if (g_inc == dsize_q) begin
            if (tcnt_q == '0) app_end = 1'b1;
            else begin
              state_d = K_TXT;
              t_d     = '0;
            end
          end
        end
        K_TXT: begin
          bsum_d  = {1'b0, bus.data_i};
          state_d = K_DATA;
        end
        K_DATA: begin
          bsum_d  = bsum_q + {1'b0, bus.data_i};
          state_d = K_BSS;
        end
        K_BSS: state_d = K_ENTRY;
        K_ENTRY: begin
          words_d = words_new;
          b_d     = '0;
          if (words_new == '0) task_end = 1'b1;
          else                 state_d  = K_BIN;
        end
        K_BIN: begin
          b_d = b_inc;
          if (b_inc == words_q) task_end = 1'b1;
        end
        default: state_d = K_DSIZE;
      endcase
    end
    if (task_end) begin
      if (t_inc == tcnt_q) app_end = 1'b1;
      else begin
        state_d = K_TXT;
        t_d     = t_inc;
      end
    end
    if (app_end) state_d = K_DSIZE;
  end

  // Oversized task counts keep parsing aligned but report the last legal index.
  always_comb begin
    task_idx  = (t_q >= FLIT_SIZE'(MAX_TASKS)) ? TW'(MAX_TASKS - 1) : t_q[TW-1:0];
    pl_in     = {bus.data_i, state_q, is_task_kind(state_q) ? task_idx : '0, app_end};
    done_d    = app_end;
    app_cnt_d = app_cnt_q + 16'(app_end);
  end

  out_reg_slice #(.W(PW)) u_out (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (acc),
    .in_data_i   (pl_in),
    .credit_o    (credit),
    .out_valid_o (bus.out_valid_o),
    .out_ready_i (bus.out_ready_i),
    .out_data_o  (pl_out)
  );

  assign bus.credit_o   = credit;
  assign bus.out_data_o = pl_out[PW-1 -: FLIT_SIZE];
  assign bus.out_kind_o = kind_t'(pl_out[TW+1 +: 4]);
  assign bus.out_task_o = pl_out[1 +: TW];
  assign bus.out_last_o = pl_out[0];
  assign app_done_o     = done_q;
  assign err_o          = err_q;
  assign app_cnt_o      = app_cnt_q;

endmodule

// File: tb/tb_app_stream_rx.sv
// Randomized scoreboard bench for app_stream_rx: layout-driven generator feeds stimulus and expectations.
module tb_app_stream_rx;
  import app_stream_pkg::*;

  localparam int MAXT = 32;

  typedef struct {
    logic [31:0] d;
    kind_t       k;
    logic [4:0]  t;
    logic        l;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        app_done_o, err_o;
  logic [15:0] app_cnt_o;

  app_stream_rx_if #(.FLIT_SIZE(32), .MAX_TASKS(MAXT)) bus ();

  app_stream_rx #(.FLIT_SIZE(32), .MAX_TASKS(MAXT)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .bus        (bus),
    .app_done_o (app_done_o),
    .err_o      (err_o),
    .app_cnt_o  (app_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;
  logic [31:0] stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] g_map[$], g_tag[$], g_graph[$], g_txt[$], g_dat[$], g_bss[$], g_ent[$];
  int  exp_apps = 0, done_seen = 0;
  bit  exp_err = 0;
  int  mode = 0;
  bit  gaps = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [4:0] sat(input int i);
    return (i >= MAXT) ? 5'(MAXT - 1) : 5'(i);
  endfunction

  function automatic void push(input logic [31:0] d, input kind_t k, input logic [4:0] t, input logic l);
    exp_t e;
    e.d = d; e.k = k; e.t = t; e.l = l;
    stim_q.push_back(d);
    exp_q.push_back(e);
  endfunction

  function automatic void clear_app();
    g_map.delete(); g_tag.delete(); g_graph.delete();
    g_txt.delete(); g_dat.delete(); g_bss.delete(); g_ent.delete();
  endfunction

  function automatic void add_task(input logic [31:0] mp, tg, tx, dt, bs, en);
    g_map.push_back(mp); g_tag.push_back(tg); g_txt.push_back(tx);
    g_dat.push_back(dt); g_bss.push_back(bs); g_ent.push_back(en);
  endfunction

  // Walks the application layout directly: header, task table, graph, then each task body.
  function automatic void push_app(input int dsize, input int tcnt);
    longint words;
    bit hdr_last;
    hdr_last = (dsize == 0) && (tcnt == 0);
    push(32'(dsize), K_DSIZE, 5'd0, 1'b0);
    push(32'(tcnt), K_TCNT, 5'd0, hdr_last);
    if (tcnt > MAXT) exp_err = 1;
    for (int i = 0; i < tcnt; i++) begin
      push(g_map[i], K_MAP, sat(i), 1'b0);
      push(g_tag[i], K_TAG, sat(i), 1'b0);
      if (g_tag[i] != 32'd1) exp_err = 1;
    end
    while (g_graph.size() < dsize) g_graph.push_back($urandom);
    for (int g = 0; g < dsize; g++)
      push(g_graph[g], K_GRAPH, 5'd0, (g == dsize - 1) && (tcnt == 0));
    for (int i = 0; i < tcnt; i++) begin
      words = (longint'(g_txt[i]) + longint'(g_dat[i])) / 4;
      push(g_txt[i], K_TXT, sat(i), 1'b0);
      push(g_dat[i], K_DATA, sat(i), 1'b0);
      push(g_bss[i], K_BSS, sat(i), 1'b0);
      push(g_ent[i], K_ENTRY, sat(i), (words == 0) && (i == tcnt - 1));
      for (longint w = 0; w < words; w++)
        push($urandom, K_BIN, sat(i), (w == words - 1) && (i == tcnt - 1));
    end
    exp_apps++;
  endfunction

  task automatic set_ready();
    case (mode)
      0:       bus.out_ready_i = 1'b1;
      1:       bus.out_ready_i = ~bus.out_ready_i;
      default: bus.out_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic drive(input int n);
    int sent = 0, stall = 0;
    while (stim_q.size() > 0 && (n < 0 || sent < n) && stall < 500) begin
      @(negedge clk_i);
      set_ready();
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.tx_i = 1'b0;
        stall++;
      end else begin
        bus.tx_i   = 1'b1;
        bus.data_i = stim_q[0];
        #1;
        if (bus.credit_o) begin
          void'(stim_q.pop_front());
          sent++;
          stall = 0;
        end else stall++;
      end
    end
    @(negedge clk_i);
    bus.tx_i = 1'b0;
    set_ready();
    chk("drive_stalled", 64'(stall >= 500), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk_i);
      set_ready();
      n++;
    end
    @(negedge clk_i);
    bus.out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic status(input string name);
    chk({name, "_err"}, 64'(err_o), 64'(exp_err));
    chk({name, "_app_cnt"}, 64'(app_cnt_o), 64'(exp_apps[15:0]));
    chk({name, "_done_pulses"}, 64'(done_seen), 64'(exp_apps));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #3 rst_ni = 1'b1;
    #1 chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_credit", 64'(bus.credit_o), 64'd0);
    stim_q.delete();
    exp_q.delete();
    exp_apps = 0; exp_err = 0; done_seen = 0;
    bus.tx_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
  endtask

  // Monitor: checks credit each cycle and compares every retired flit against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_ni) begin
        chk("credit", 64'(bus.credit_o), 64'(!bus.out_valid_o || bus.out_ready_i));
        if (app_done_o) done_seen++;
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (exp_q.size() == 0) chk("unexpected_out", 64'(bus.out_data_o), 64'hDEAD_BEEF_0000);
          else begin
            e = exp_q.pop_front();
            chk("out_flit",
                {22'd0, bus.out_last_o, bus.out_task_o, 4'(bus.out_kind_o), bus.out_data_o},
                {22'd0, e.l, e.t, 4'(e.k), e.d});
          end
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b1;
    bus.tx_i = 1'b0; bus.data_i = '0; bus.out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("reset_valid", 64'(bus.out_valid_o), 64'd0);
    chk("reset_data", 64'(bus.out_data_o), 64'd0);
    chk("reset_kind", 64'(bus.out_kind_o), 64'(K_DSIZE));
    chk("reset_task", 64'(bus.out_task_o), 64'd0);
    chk("reset_last", 64'(bus.out_last_o), 64'd0);
    chk("reset_done", 64'(app_done_o), 64'd0);
    chk("reset_err", 64'(err_o), 64'd0);
    chk("reset_cnt", 64'(app_cnt_o), 64'd0);
    chk("reset_credit", 64'(bus.credit_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b0;

    // Reference application, ready tied high.
    clear_app();
    g_graph.push_back(32'hA); g_graph.push_back(32'hB);
    add_task(5, 1, 8, 4, 0, 32'h100);
    add_task(7, 1, 4, 0, 16, 32'h200);
    mode = 0; gaps = 0;
    push_app(2, 2);
    drive(-1); drain(); status("ref");

    // Same stream under backpressure and input gaps.
    mode = 1; gaps = 1;
    push_app(2, 2);
    drive(-1); drain(); status("ref_bp");

    // Minimal application and a 6+0 task (one binary word).
    clear_app();
    mode = 0; gaps = 0;
    push_app(0, 0);
    add_task(3, 1, 6, 0, 2, 32'h40);
    push_app(1, 1);
    drive(-1); drain(); status("min_txt6");

    // Random applications with random backpressure.
    mode = 2; gaps = 1;
    for (int a = 0; a < 8; a++) begin
      int ds, tc;
      clear_app();
      ds = $urandom_range(0, 3);
      tc = $urandom_range(0, 3);
      for (int i = 0; i < tc; i++)
        add_task($urandom, 1, $urandom_range(0, 40), $urandom_range(0, 40), $urandom, $urandom);
      push_app(ds, tc);
    end
    drive(-1); drain(); status("rand");

    // Bad tag sets the sticky error; parsing continues.
    clear_app();
    mode = 0; gaps = 0;
    add_task(1, 1, 4, 0, 0, 0);
    add_task(2, 3, 0, 8, 0, 0);
    push_app(1, 2);
    push_app(0, 0);
    drive(-1); drain(); status("bad_tag");

    // Task count above the maximum.
    do_reset();
    clear_app();
    mode = 2; gaps = 0;
    for (int i = 0; i < MAXT + 1; i++) add_task(i, 1, (i == MAXT) ? 8 : 0, 0, 0, i);
    push_app(0, MAXT + 1);
    drive(-1); drain(); status("tcnt_over");

    // Reset in the middle of a binary payload.
    do_reset();
    clear_app();
    mode = 0; gaps = 0;
    add_task(1, 1, 40, 0, 0, 0);
    push_app(0, 1);
    drive(10);
    do_reset();
    chk("post_rst_cnt", 64'(app_cnt_o), 64'd0);
    chk("post_rst_err", 64'(err_o), 64'd0);
    clear_app();
    push_app(0, 0);
    drive(-1); drain(); status("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
